// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

   localparam int unsigned ILEN    = 32;
   localparam int unsigned PC_STEP = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FAULT = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO for fetched {pc, instr} entries.
// Ports: push_i/pop_i/flush_i control, din_i write data, dout_o head entry,
//        count_o occupancy, full_o/empty_o status.
// Flush wins over push and pop; push+pop on a full queue is legal.
module fetch_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter type         T     = logic [63:0]
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic                       flush_i,
   input  T                           din_i,
   output T                           dout_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       full_o,
   output logic                       empty_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   T              mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q;
   logic [PW-1:0] rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          do_pop;

   assign do_pop  = pop_i && (count_q != '0);
   assign dout_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;
   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);

   // Storage is reset so the head never reads X after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) begin
            mem_q[wr_ptr_q] <= din_i;
            wr_ptr_q        <= wr_ptr_q + PW'(1);
         end
         if (do_pop) rd_ptr_q <= rd_ptr_q + PW'(1);
         count_q <= count_q + CW'(push_i) - CW'(do_pop);
      end
   end

   // Push into a full queue needs a simultaneous pop; pop needs an entry.
   a_no_ovf_unf: assert property (@(posedge clk) disable iff (!rst_n)
      !flush_i |-> (!(push_i && full_o && !pop_i) && !(pop_i && empty_o)));

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the combinational
// instruction memory, queues {pc, instr} toward decode, handles redirects
// and out-of-range / misaligned fetch faults.
// Ports: start_i leaves IDLE; imem_addr_o/imem_data_i memory interface;
//        redirect_valid_i/redirect_pc_i from execute; out_* valid/ready head
//        of the fetch queue; fault_o/fault_pc_o fault status.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned FQ_DEPTH = 4,
   parameter int unsigned MEM_DEP  = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start_i,
   output logic [ILEN-1:0] imem_addr_o,
   input  logic [ILEN-1:0] imem_data_i,
   input  logic            redirect_valid_i,
   input  logic [ILEN-1:0] redirect_pc_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [ILEN-1:0] out_instr_o,
   output logic [ILEN-1:0] out_pc_o,
   output logic            fault_o,
   output logic [ILEN-1:0] fault_pc_o
);

   localparam int unsigned CW = $clog2(FQ_DEPTH) + 1;

   fetch_state_t    state_q, state_d;
   logic [ILEN-1:0] pc_q, pc_d;
   logic [ILEN-1:0] fault_pc_q, fault_pc_d;

   logic            pc_legal;
   logic            redir_misaligned;
   logic            pop;
   logic            push;
   logic            fq_full;
   logic            fq_empty;
   logic [CW-1:0]   fq_count;
   fetch_entry_t    fq_din;
   fetch_entry_t    fq_dout;

   assign pc_legal         = (pc_q[31:2] < 30'(MEM_DEP));
   assign redir_misaligned = (redirect_pc_i[1:0] != 2'b00);
   assign pop              = out_valid_o && out_ready_i;
   // A full queue still has space when its head leaves in the same cycle.
   assign push             = (state_q == RUN) && pc_legal && (!fq_full || pop)
                             && !redirect_valid_i;
   assign fq_din           = '{pc: pc_q, instr: imem_data_i};

   fetch_fifo #(
      .DEPTH (FQ_DEPTH),
      .T     (fetch_entry_t)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .pop_i   (pop),
      .flush_i (redirect_valid_i),
      .din_i   (fq_din),
      .dout_o  (fq_dout),
      .count_o (fq_count),
      .full_o  (fq_full),
      .empty_o (fq_empty)
   );

   assign imem_addr_o = pc_q;
   assign out_valid_o = !fq_empty;
   assign out_pc_o    = fq_dout.pc;
   assign out_instr_o = fq_dout.instr;
   assign fault_o     = (state_q == FAULT);
   assign fault_pc_o  = fault_pc_q;

   // State, PC and fault-PC registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         pc_q       <= RESET_PC;
         fault_pc_q <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         fault_pc_q <= fault_pc_d;
      end
   end

   // Next state: a redirect overrides everything else in the cycle.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      fault_pc_d = fault_pc_q;
      if (redirect_valid_i) begin
         pc_d = redirect_pc_i;
         if (redir_misaligned) begin
            state_d    = FAULT;
            fault_pc_d = redirect_pc_i;
         end else if (state_q == IDLE) begin
            state_d = start_i ? RUN : IDLE;
         end else begin
            state_d = RUN;
         end
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start_i) state_d = RUN;
            end
            RUN: begin
               if (!pc_legal) begin
                  state_d    = FAULT;
                  fault_pc_d = pc_q;
               end else if (push) begin
                  pc_d = pc_q + ILEN'(PC_STEP);
               end
            end
            FAULT: ;
            default: state_d = IDLE;
         endcase
      end
   end

   a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
      fq_count <= CW'(FQ_DEPTH));

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: stimulus queues expected {pc, instr}
// pairs, a negedge monitor checks every completed handshake against them.
module tb_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_i;
   logic [31:0] imem_addr_o;
   logic [31:0] imem_data_i;
   logic        redirect_valid_i;
   logic [31:0] redirect_pc_i;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [31:0] out_instr_o;
   logic [31:0] out_pc_o;
   logic        fault_o;
   logic [31:0] fault_pc_o;

   int          total = 0;
   int          bad   = 0;
   logic [63:0] exp_q [$];

   always #5 clk = ~clk;

   // Memory word i holds 0x1000_0000 + i.
   assign imem_data_i = 32'h1000_0000 + (imem_addr_o >> 2);

   fetch_ctrl dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .start_i          (start_i),
      .imem_addr_o      (imem_addr_o),
      .imem_data_i      (imem_data_i),
      .redirect_valid_i (redirect_valid_i),
      .redirect_pc_i    (redirect_pc_i),
      .out_valid_o      (out_valid_o),
      .out_ready_i      (out_ready_i),
      .out_instr_o      (out_instr_o),
      .out_pc_o         (out_pc_o),
      .fault_o          (fault_o),
      .fault_pc_o       (fault_pc_o)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic exp_push(input logic [31:0] pc);
      exp_q.push_back({pc, 32'h1000_0000 + (pc >> 2)});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wait until every expected entry is consumed, then drop ready.
   task automatic drain(input string name);
      for (int i = 0; i < 64; i++) begin
         @(posedge clk);
         if (exp_q.size() == 0) break;
      end
      #1;
      check(name, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      out_ready_i = 1'b0;
   endtask

   task automatic do_reset();
      rst_n            = 1'b0;
      start_i          = 1'b0;
      redirect_valid_i = 1'b0;
      redirect_pc_i    = '0;
      out_ready_i      = 1'b0;
      exp_q.delete();
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   // Monitor: every accepted head must match the next expected pair.
   always @(negedge clk) begin
      logic [63:0] e;
      if (rst_n && out_valid_o && out_ready_i) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_pop: got pc=%h instr=%h want none", out_pc_o, out_instr_o);
         end else begin
            e = exp_q.pop_front();
            check("head_pc", out_pc_o, e[63:32]);
            check("head_instr", out_instr_o, e[31:0]);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values
      rst_n = 1'b0;
      start_i = 1'b0; redirect_valid_i = 1'b0; redirect_pc_i = '0; out_ready_i = 1'b0;
      #3;
      check("rst_valid", 32'(out_valid_o), 32'd0);
      check("rst_pc", out_pc_o, 32'd0);
      check("rst_instr", out_instr_o, 32'd0);
      check("rst_fault", 32'(fault_o), 32'd0);
      check("rst_fault_pc", fault_pc_o, 32'd0);
      check("rst_addr", imem_addr_o, 32'd0);

      // 1: streaming with ready high, latency start->valid is two cycles
      do_reset();
      out_ready_i = 1'b1;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      for (int i = 0; i < 8; i++) exp_push(32'(i * 4));
      @(negedge clk);
      check("lat_n1_valid", 32'(out_valid_o), 32'd0);
      tick();
      @(negedge clk);
      check("lat_n2_valid", 32'(out_valid_o), 32'd1);
      drain("t1_drain");

      // 2: backpressure fills the queue, PC holds at 0x10
      do_reset();
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      repeat (8) tick();
      @(negedge clk);
      check("t2_addr_hold", imem_addr_o, 32'h10);
      check("t2_valid", 32'(out_valid_o), 32'd1);
      check("t2_head_pc", out_pc_o, 32'h0);
      for (int i = 0; i < 8; i++) exp_push(32'(i * 4));
      tick();
      out_ready_i = 1'b1;
      drain("t2_drain");

      // 3: redirect with three queued entries and a same-cycle pop
      do_reset();
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      repeat (3) tick();
      redirect_valid_i = 1'b1;
      redirect_pc_i    = 32'h40;
      out_ready_i      = 1'b1;
      exp_push(32'h0);
      tick();
      redirect_valid_i = 1'b0;
      exp_push(32'h40); exp_push(32'h44); exp_push(32'h48);
      @(negedge clk);
      check("t3_flushed", 32'(out_valid_o), 32'd0);
      check("t3_addr", imem_addr_o, 32'h40);
      drain("t3_drain");

      // 4: run off the end of memory, drain, then recover
      redirect_valid_i = 1'b1;
      redirect_pc_i    = 32'hF8;
      tick();
      redirect_valid_i = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      check("t4_fault", 32'(fault_o), 32'd1);
      check("t4_fault_pc", fault_pc_o, 32'h100);
      check("t4_valid", 32'(out_valid_o), 32'd1);
      repeat (2) tick();
      check("t4_addr_hold", imem_addr_o, 32'h100);
      exp_push(32'hF8); exp_push(32'hFC);
      out_ready_i = 1'b1;
      drain("t4_drain");
      tick();
      check("t4_no_push", 32'(out_valid_o), 32'd0);
      redirect_valid_i = 1'b1;
      redirect_pc_i    = 32'h0;
      out_ready_i      = 1'b1;
      exp_push(32'h0); exp_push(32'h4); exp_push(32'h8);
      tick();
      redirect_valid_i = 1'b0;
      @(negedge clk);
      check("t4_fault_clr", 32'(fault_o), 32'd0);
      drain("t4_resume");

      // 5: misaligned redirect while running
      tick();
      redirect_valid_i = 1'b1;
      redirect_pc_i    = 32'h22;
      tick();
      redirect_valid_i = 1'b0;
      @(negedge clk);
      check("t5_fault", 32'(fault_o), 32'd1);
      check("t5_fault_pc", fault_pc_o, 32'h22);
      check("t5_flushed", 32'(out_valid_o), 32'd0);
      repeat (3) tick();
      @(negedge clk);
      check("t5_no_push", 32'(out_valid_o), 32'd0);
      check("t5_addr", imem_addr_o, 32'h22);
      tick();
      redirect_valid_i = 1'b1;
      redirect_pc_i    = 32'h80;
      out_ready_i      = 1'b1;
      exp_push(32'h80); exp_push(32'h84); exp_push(32'h88);
      tick();
      redirect_valid_i = 1'b0;
      drain("t5_drain");
      check("t5_fault_clr", 32'(fault_o), 32'd0);

      // 6: asynchronous reset with a full queue
      repeat (6) tick();
      @(negedge clk);
      check("t6_full_valid", 32'(out_valid_o), 32'd1);
      tick();
      #1 rst_n = 1'b0;
      #1;
      check("t6_async_valid", 32'(out_valid_o), 32'd0);
      check("t6_async_pc", out_pc_o, 32'd0);
      check("t6_async_instr", out_instr_o, 32'd0);
      check("t6_async_addr", imem_addr_o, 32'd0);
      rst_n = 1'b1;
      exp_q.delete();
      repeat (3) tick();
      @(negedge clk);
      check("t6_idle_valid", 32'(out_valid_o), 32'd0);
      check("t6_idle_addr", imem_addr_o, 32'd0);
      tick();
      redirect_valid_i = 1'b1;
      redirect_pc_i    = 32'h20;
      tick();
      redirect_valid_i = 1'b0;
      repeat (2) tick();
      @(negedge clk);
      check("t6_idle_redir_addr", imem_addr_o, 32'h20);
      check("t6_idle_redir_valid", 32'(out_valid_o), 32'd0);
      tick();
      out_ready_i = 1'b1;
      start_i     = 1'b1;
      for (int i = 0; i < 4; i++) exp_push(32'h20 + 32'(i * 4));
      tick();
      start_i = 1'b0;
      drain("t6_drain");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Instruction-fetch sequencer for the in-order core. It owns the PC, drives the address of the combinational instruction memory (word-indexed by addr>>2, MEM_DEP words) and captures the returned word each cycle. Fetched {pc, instr} pairs are buffered in a small FIFO toward decode with a valid/ready handshake. It also handles redirects from execute and out-of-range or misaligned fetch faults.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.
FQ_DEPTH, 4, fetch-queue entries; power of two, at least 2.
MEM_DEP, 64, instruction-memory depth in 32-bit words; legal PC iff (pc>>2) < MEM_DEP.

Ports:
clk  in  1  core clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start_i  in  1  pulse: leave IDLE and begin fetching at current PC.
imem_addr_o  out  32  byte address to instruction memory; equals the PC register.
imem_data_i  in  32  instruction word, combinational from imem_addr_o in the same cycle.
redirect_valid_i  in  1  branch/jump redirect strobe.
redirect_pc_i  in  32  redirect target.
out_valid_o  out  1  queue head valid.
out_ready_i  in  1  decode accepts head.
out_instr_o  out  32  head instruction.
out_pc_o  out  32  head PC.
fault_o  out  1  high while in FAULT.
fault_pc_o  out  32  offending PC, held while fault_o is high.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, pc=RESET_PC, queue empty.
  - out_valid_o=0, out_instr_o=0, out_pc_o=0, fault_o=0, fault_pc_o=0.
  - A reset mid-operation discards all queue contents immediately.
- States are IDLE, RUN and FAULT.
  - IDLE->RUN on start_i.
  - RUN->FAULT when the PC is out of range.
  - Any state->FAULT on a misaligned redirect (redirect_pc_i[1:0]!=0).
  - FAULT->RUN on a legal redirect.
  - FAULT is left only by redirect or reset.
- Push (RUN only): push when the PC is legal and there is space.
  - Space means count<FQ_DEPTH, or count==FQ_DEPTH with a pop in the same cycle.
  - The entry is {pc, imem_data_i}; then pc<=pc+4 (32-bit wraparound).
  - With no space, pc holds and imem_addr_o is stable.
- Latency: start_i in cycle N -> fetch of RESET_PC in N+1 -> out_valid_o=1 in N+2.
  - Throughput is 1 instruction/cycle when out_ready_i is held high.
- Pop: a pop occurs when out_valid_o && out_ready_i.
  - out_* reflect the queue head registers; out_valid_o = (count!=0).
  - out_instr_o/out_pc_o are don't-care when invalid and must not be X after reset.
- Out-of-range PC in RUN: no push; state<=FAULT; fault_pc_o<=pc.
  - Entries already queued keep draining normally.
- Redirect has priority over push in the same cycle. On redirect_valid_i:
  - The queue is flushed (count<=0) and no push happens that cycle.
  - A handshake completing in the same cycle is still considered consumed.
  - pc<=redirect_pc_i.
  - If misaligned: state<=FAULT, fault_pc_o<=redirect_pc_i.
  - Otherwise: IDLE stays IDLE; RUN/FAULT->RUN; fault_o clears next cycle.
  - A legal-aligned but out-of-range target enters RUN, then faults on the following cycle.
- start_i outside IDLE is ignored. start_i together with a redirect in IDLE: the redirect loads pc, then the state moves to RUN.
- Queue pointers are log2(FQ_DEPTH) bits and wrap naturally. count is log2(FQ_DEPTH)+1 bits.
  - Overflow and underflow are impossible by construction; an assertion checks this.

Decomposition:
- Package fetch_pkg holds:
  - the state enum fetch_state_t {IDLE, RUN, FAULT};
  - the struct fetch_entry_t {pc[31:0], instr[31:0]};
  - localparams ILEN=32 and PC_STEP=4.
- Sub-module fetch_fifo: a synchronous FIFO parameterised by depth and entry type.
  - Ports: push, pop, flush, din, dout, count, full, empty.
  - Same-cycle push+pop when full is allowed; flush has priority over push and pop.
- fetch_ctrl holds the PC, the FSM and the space/redirect logic.

Test Plan:
Use defaults (RESET_PC=0, FQ_DEPTH=4, MEM_DEP=64), with memory word i = 32'h1000_0000+i.
1. Reset then start_i at cycle 2, out_ready_i=1 -> out_valid_o from cycle 4; pairs (0x0,0x10000000), (0x4,0x10000001), ... one per cycle, no gaps.
2. out_ready_i=0 after start -> exactly 4 entries (pc 0x0..0xC) queued; imem_addr_o holds 0x10; raise ready -> entries drain in order, then 0x10 follows with no loss or duplication.
3. Queue holding 3 entries, redirect_valid_i=1 to 0x40 with a simultaneous pop -> next cycle count=0, out_valid_o=0; following cycle head = (0x40, 0x10000010).
4. Redirect to 0xF8 -> 0xF8 and 0xFC are fetched; PC 0x100 gives no push; fault_o=1 and fault_pc_o=0x100; queued entries still drain; redirect to 0x0 clears fault_o and resumes at 0x0.
5. Redirect to 0x22 (misaligned) while in RUN -> queue flushed, fault_o=1, fault_pc_o=0x22, no pushes until a legal redirect.
6. Assert rst_n low for a partial cycle with a full queue -> outputs go to reset values asynchronously; after release state=IDLE and nothing is fetched until start_i.
